// File: rtl/ctrl_ramdrv_pkg.sv
// Shared controller package for the RAM-driver blocks (tap reader and head-pointer block).
// Holds the tap-reader state encoding and the default width constants.
package ctrl_ramdrv_pkg;

    localparam int DEF_DATA_OFFSET_WIDTH  = 10;
    localparam int DEF_VECTOR_INDEX_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEAD_REQ = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } tap_state_e;

endpackage

// File: rtl/ctrl_ramdrv_tap_reader_if.sv
// Bus bundle between the tap reader (slave) and its controller, head-pointer block and RAM/MAC side (master).
interface ctrl_ramdrv_tap_reader_if
    import ctrl_ramdrv_pkg::*;
#(
    parameter int DATA_OFFSET_WIDTH  = DEF_DATA_OFFSET_WIDTH,
    parameter int VECTOR_INDEX_WIDTH = DEF_VECTOR_INDEX_WIDTH
);

    logic                                        start;
    logic [VECTOR_INDEX_WIDTH-1:0]               index;
    logic [DATA_OFFSET_WIDTH-1:0]                length;
    logic                                        head_req;
    logic [DATA_OFFSET_WIDTH-1:0]                head_offset;
    logic                                        rd_en;
    logic                                        rd_ready;
    logic [VECTOR_INDEX_WIDTH+DATA_OFFSET_WIDTH-1:0] rd_addr;
    logic                                        tap_first;
    logic                                        tap_last;
    logic                                        busy;
    logic                                        done;
    logic                                        err;

    modport master (
        output start, index, length, head_offset, rd_ready,
        input  head_req, rd_en, rd_addr, tap_first, tap_last, busy, done, err
    );

    modport slave (
        input  start, index, length, head_offset, rd_ready,
        output head_req, rd_en, rd_addr, tap_first, tap_last, busy, done, err
    );

endinterface

// File: rtl/ctrl_ramdrv_offset_dec.sv
// Circular backwards step of a per-vector offset: 0 wraps to length, otherwise offset-1.
module ctrl_ramdrv_offset_dec
    import ctrl_ramdrv_pkg::*;
#(
    parameter int DATA_OFFSET_WIDTH = DEF_DATA_OFFSET_WIDTH
) (
    input  logic [DATA_OFFSET_WIDTH-1:0] offset,
    input  logic [DATA_OFFSET_WIDTH-1:0] length,
    output logic [DATA_OFFSET_WIDTH-1:0] next_offset
);

    // Wrap to the last valid offset instead of underflowing past zero.
    always_comb begin
        next_offset = offset - 1'b1;
        if (offset == '0) begin
            next_offset = length;
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_tap_reader.sv
// Tap reader: fetches the head pointer of one vector, then streams its taps newest-first
// as {index, offset} RAM addresses with first/last qualifiers, finishing with a done pulse.
module ctrl_ramdrv_tap_reader
    import ctrl_ramdrv_pkg::*;
#(
    parameter int DATA_OFFSET_WIDTH  = DEF_DATA_OFFSET_WIDTH,
    parameter int VECTOR_INDEX_WIDTH = DEF_VECTOR_INDEX_WIDTH
) (
    input logic                    clk,
    input logic                    rst_n,
    ctrl_ramdrv_tap_reader_if.slave bus
);

    tap_state_e                    state_q, state_d;
    logic [VECTOR_INDEX_WIDTH-1:0] index_q, index_d;
    logic [DATA_OFFSET_WIDTH-1:0]  length_q, length_d;
    logic [DATA_OFFSET_WIDTH-1:0]  offset_q, offset_d;
    logic [DATA_OFFSET_WIDTH-1:0]  count_q, count_d;
    logic                          err_q, err_d;

    logic [DATA_OFFSET_WIDTH-1:0]  next_offset;
    logic                          in_stream;
    logic                          transfer;
    logic                          at_last;
    logic                          head_bad;

    assign in_stream = (state_q == STREAM);
    assign transfer  = in_stream && bus.rd_ready;
    assign at_last   = (count_q == length_q);
    assign head_bad  = (bus.head_offset > length_q);

    ctrl_ramdrv_offset_dec #(
        .DATA_OFFSET_WIDTH(DATA_OFFSET_WIDTH)
    ) u_offset_dec (
        .offset     (offset_q),
        .length     (length_q),
        .next_offset(next_offset)
    );

    // State and datapath registers; reset clears everything so all outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            index_q  <= '0;
            length_q <= '0;
            offset_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            length_q <= length_d;
            offset_q <= offset_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: a corrupt head pointer bypasses STREAM entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = HEAD_REQ;
                end
            end
            HEAD_REQ: begin
                state_d = head_bad ? DONE : STREAM;
            end
            STREAM: begin
                if (transfer && at_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath updates: latch the request, load the head, and step one tap per accepted address.
    always_comb begin
        index_d  = index_q;
        length_d = length_q;
        offset_d = offset_q;
        count_d  = count_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    index_d  = bus.index;
                    length_d = bus.length;
                end
            end
            HEAD_REQ: begin
                offset_d = bus.head_offset;
                count_d  = '0;
                err_d    = head_bad;
            end
            STREAM: begin
                if (transfer) begin
                    offset_d = next_offset;
                    count_d  = count_q + 1'b1;
                end
            end
            DONE: begin
                err_d = 1'b0;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    // Outputs decoded purely from registered state so they hold steady while a transfer is stalled.
    always_comb begin
        bus.head_req  = (state_q == HEAD_REQ);
        bus.rd_en     = in_stream;
        bus.rd_addr   = {index_q, offset_q};
        bus.tap_first = in_stream && (count_q == '0);
        bus.tap_last  = in_stream && at_last;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.err       = (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_ctrl_ramdrv_tap_reader.sv
// Directed self-checking bench for the tap reader: fixed vectors with hand-computed addresses.
module tb_ctrl_ramdrv_tap_reader;

    logic clk;
    logic rst_n;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int xfer_cnt  = 0;
    int done_cnt  = 0;
    int xfer_base;
    int done_base;

    ctrl_ramdrv_tap_reader_if #(
        .DATA_OFFSET_WIDTH (10),
        .VECTOR_INDEX_WIDTH(4)
    ) bus ();

    ctrl_ramdrv_tap_reader #(
        .DATA_OFFSET_WIDTH (10),
        .VECTOR_INDEX_WIDTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count accepted addresses and done pulses as an independent tally.
    always @(posedge clk) begin
        if (bus.rd_en && bus.rd_ready) begin
            xfer_cnt <= xfer_cnt + 1;
        end
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic applyStimulus(input logic s, input logic [3:0] idx, input logic [9:0] len,
                                 input logic [9:0] head, input logic rdy);
        bus.start       = s;
        bus.index       = idx;
        bus.length      = len;
        bus.head_offset = head;
        bus.rd_ready    = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks every output; exp_addr < 0 means the address is not meaningful in that cycle.
    task automatic checkAll(input string tag, input logic hr, input logic en, input int exp_addr,
                            input logic first, input logic last, input logic bsy,
                            input logic dn, input logic er);
        checkOutput({tag, ".head_req"},  {31'd0, bus.head_req},  {31'd0, hr});
        checkOutput({tag, ".rd_en"},     {31'd0, bus.rd_en},     {31'd0, en});
        if (exp_addr >= 0) begin
            checkOutput({tag, ".rd_addr"}, {18'd0, bus.rd_addr}, exp_addr);
        end
        checkOutput({tag, ".tap_first"}, {31'd0, bus.tap_first}, {31'd0, first});
        checkOutput({tag, ".tap_last"},  {31'd0, bus.tap_last},  {31'd0, last});
        checkOutput({tag, ".busy"},      {31'd0, bus.busy},      {31'd0, bsy});
        checkOutput({tag, ".done"},      {31'd0, bus.done},      {31'd0, dn});
        checkOutput({tag, ".err"},       {31'd0, bus.err},       {31'd0, er});
    endtask

    task automatic checkTap(input string tag, input int addr, input logic first, input logic last);
        checkAll(tag, 1'b0, 1'b1, addr, first, last, 1'b1, 1'b0, 1'b0);
    endtask

    // Linear directed sequence.
    initial begin
        applyStimulus(1'b0, 4'd0, 10'd0, 10'd0, 1'b1);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkAll("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #9 rst_n = 1'b1;
        tick();
        checkAll("idle", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // index 2, length 3, head 1: wraps 1,0,3,2
        applyStimulus(1'b1, 4'd2, 10'd3, 10'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd2, 10'd3, 10'd1, 1'b1);
        checkAll("basic.head", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); checkTap("basic.tap0", 'h801, 1'b1, 1'b0);
        tick(); checkTap("basic.tap1", 'h800, 1'b0, 1'b0);
        tick(); checkTap("basic.tap2", 'h803, 1'b0, 1'b0);
        tick(); checkTap("basic.tap3", 'h802, 1'b0, 1'b1);
        tick(); checkAll("basic.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(); checkAll("basic.idle", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // length 0: single tap that is both first and last
        applyStimulus(1'b1, 4'd0, 10'd0, 10'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 10'd0, 10'd0, 1'b1);
        checkAll("len0.head", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); checkTap("len0.tap0", 'h000, 1'b1, 1'b1);
        tick(); checkAll("len0.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(); checkAll("len0.idle", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-pressure on the second tap for three cycles
        xfer_base = xfer_cnt;
        applyStimulus(1'b1, 4'd2, 10'd3, 10'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd2, 10'd3, 10'd1, 1'b1);
        tick(); checkTap("stall.tap0", 'h801, 1'b1, 1'b0);
        tick(); checkTap("stall.tap1", 'h800, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd2, 10'd3, 10'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkTap("stall.hold", 'h800, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 4'd2, 10'd3, 10'd1, 1'b1);
        tick(); checkTap("stall.tap2", 'h803, 1'b0, 1'b0);
        tick(); checkTap("stall.tap3", 'h802, 1'b0, 1'b1);
        tick(); checkAll("stall.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("stall.xfers", xfer_cnt - xfer_base, 4);

        // corrupt head: 5 > length 3
        tick();
        xfer_base = xfer_cnt;
        applyStimulus(1'b1, 4'd0, 10'd3, 10'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 10'd3, 10'd5, 1'b1);
        checkAll("badhead.head", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); checkAll("badhead.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(); checkAll("badhead.idle", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("badhead.xfers", xfer_cnt - xfer_base, 0);

        // reset mid-stream after two taps, then a fresh start right after release
        applyStimulus(1'b1, 4'd2, 10'd3, 10'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd2, 10'd3, 10'd1, 1'b1);
        tick(); checkTap("rst.tap0", 'h801, 1'b1, 1'b0);
        tick(); checkTap("rst.tap1", 'h800, 1'b0, 1'b0);
        tick(); checkTap("rst.tap2", 'h803, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkAll("rst.async", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 4'd1, 10'd3, 10'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd1, 10'd3, 10'd3, 1'b1);
        checkAll("rst.head", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); checkTap("rst.new0", 'h403, 1'b1, 1'b0);
        tick(); checkTap("rst.new1", 'h402, 1'b0, 1'b0);
        tick(); checkTap("rst.new2", 'h401, 1'b0, 1'b0);
        tick(); checkTap("rst.new3", 'h400, 1'b0, 1'b1);
        tick(); checkAll("rst.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // start held during STREAM and DONE must be ignored
        tick();
        done_base = done_cnt;
        applyStimulus(1'b1, 4'd3, 10'd1, 10'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd3, 10'd1, 10'd0, 1'b1);
        checkAll("ign.head", 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); checkTap("ign.tap0", 'hC00, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd5, 10'd2, 10'd0, 1'b1);
        tick(); checkTap("ign.tap1", 'hC01, 1'b0, 1'b1);
        tick(); checkAll("ign.done", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(); checkAll("ign.idle0", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd5, 10'd2, 10'd0, 1'b1);
        tick(); checkAll("ign.idle1", 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ign.dones", done_cnt - done_base, 1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
